// File: rtl/manhattan_ring_generator_if.sv
// Point-stream bundle between the ring generator and its consumer.
// The master side is the generator and the slave side is the command source or consumer.
interface manhattan_ring_generator_if;
  logic       start;
  logic [3:0] center_x;
  logic [3:0] center_y;
  logic [3:0] radius;
  logic       out_ready;
  logic       out_valid;
  logic [3:0] out_x;
  logic [3:0] out_y;
  logic       busy;
  logic       done;
  logic [5:0] point_count;

  modport master (
    input  start, center_x, center_y, radius, out_ready,
    output out_valid, out_x, out_y, busy, done, point_count
  );

  modport slave (
    output start, center_x, center_y, radius, out_ready,
    input  out_valid, out_x, out_y, busy, done, point_count
  );
endinterface

// File: rtl/manhattan_ring_generator.sv
// Enumerates on-grid points at Manhattan distance R from (cx,cy): 1 SCAN cycle per candidate, >=1 EMIT cycle per point.
// Backpressure: EMIT holds out_valid and the point stable until out_ready; start is ignored while busy.
module manhattan_ring_generator (
  input  logic                        clk,
  input  logic                        rst,
  manhattan_ring_generator_if.master  ring
);

  typedef enum logic [1:0] {IDLE, SCAN, EMIT, DONE} state_t;

  state_t      state, state_nxt;
  logic [3:0]  cx, cy, r;
  logic [1:0]  seg;
  logic [3:0]  step;
  logic [3:0]  pt_x, pt_y;
  logic [5:0]  pt_count;

  logic signed [5:0] ecx, ecy, er, ei;
  logic signed [5:0] cand_x, cand_y;
  logic in_bounds, last;
  logic load, advance, capture, accept;

  assign ecx = {2'b00, cx};
  assign ecy = {2'b00, cy};
  assign er  = {2'b00, r};
  assign ei  = {2'b00, step};

  // Candidate k is tracked as (seg, step) so no divider is needed.
  always_comb begin
    cand_x = ecx;
    cand_y = ecy;
    case (seg)
      2'd0: begin cand_x = ecx + er - ei; cand_y = ecy + ei;      end
      2'd1: begin cand_x = ecx - ei;      cand_y = ecy + er - ei; end
      2'd2: begin cand_x = ecx - er + ei; cand_y = ecy - ei;      end
      default: begin cand_x = ecx + ei;   cand_y = ecy - er + ei; end
    endcase
  end

  // Candidates span -15..30, so bits [5:4] are zero exactly when 0..15.
  assign in_bounds = (cand_x[5:4] == 2'b00) && (cand_y[5:4] == 2'b00);
  assign last      = (r == 4'd0) || ((seg == 2'd3) && (step == r - 4'd1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    load      = 1'b0;
    advance   = 1'b0;
    capture   = 1'b0;
    accept    = 1'b0;
    case (state)
      IDLE: begin
        if (ring.start) begin
          load      = 1'b1;
          state_nxt = SCAN;
        end
      end
      SCAN: begin
        if (in_bounds) begin
          capture   = 1'b1;
          state_nxt = EMIT;
        end else if (last) begin
          state_nxt = DONE;
        end else begin
          advance   = 1'b1;
        end
      end
      EMIT: begin
        if (ring.out_ready) begin
          accept = 1'b1;
          if (last) begin
            state_nxt = DONE;
          end else begin
            advance   = 1'b1;
            state_nxt = SCAN;
          end
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cx       <= '0;
      cy       <= '0;
      r        <= '0;
      seg      <= '0;
      step     <= '0;
      pt_x     <= '0;
      pt_y     <= '0;
      pt_count <= '0;
    end else begin
      if (load) begin
        cx       <= ring.center_x;
        cy       <= ring.center_y;
        r        <= ring.radius;
        seg      <= '0;
        step     <= '0;
        pt_count <= '0;
      end
      if (advance) begin
        if (step == r - 4'd1) begin
          step <= '0;
          seg  <= seg + 2'd1;
        end else begin
          step <= step + 4'd1;
        end
      end
      if (capture) begin
        pt_x <= cand_x[3:0];
        pt_y <= cand_y[3:0];
      end
      if (accept) pt_count <= pt_count + 6'd1;
    end
  end

  assign ring.out_valid   = (state == EMIT);
  assign ring.busy        = (state != IDLE);
  assign ring.done        = (state == DONE);
  assign ring.out_x       = pt_x;
  assign ring.out_y       = pt_y;
  assign ring.point_count = pt_count;

endmodule

// File: tb/tb_manhattan_ring_generator.sv
// Scoreboard bench for manhattan_ring_generator: stimulus pushes expected points and run totals,
// a negedge monitor pops and compares on every transfer and every done pulse.
module tb_manhattan_ring_generator;

  logic clk;
  logic rst;

  manhattan_ring_generator_if ring_if();

  manhattan_ring_generator dut (
    .clk  (clk),
    .rst  (rst),
    .ring (ring_if)
  );

  typedef struct { int x; int y; }     pt_t;
  typedef struct { int cnt; int cyc; } run_t;

  pt_t  exp_q[$];
  run_t run_q[$];

  int n_cmp = 0;
  int n_err = 0;
  int pts_seen = 0;
  int done_seen = 0;
  int busy_cycles = 0;
  int cur_cx = 0, cur_cy = 0, cur_r = 0;
  bit seen[256];
  bit stall_en = 0;
  int stall_cnt = 0;
  bit prev_hold = 0, prev_done = 0;
  int hold_x = 0, hold_y = 0;

  initial clk = 0;
  always #5 clk = ~clk;

  task automatic check(input string name, input int act, input int req);
    n_cmp++;
    if (act != req) begin
      n_err++;
      $display("FAIL %s: got %0d, required %0d", name, act, req);
    end
  endtask

  task automatic push_pt(input int x, input int y);
    pt_t p;
    p.x = x;
    p.y = y;
    exp_q.push_back(p);
  endtask

  // Consumer: ready always, or 5 low cycles at each presented point.
  initial begin
    ring_if.out_ready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      if (!stall_en) begin
        ring_if.out_ready = 1'b1;
      end else if (ring_if.out_valid) begin
        if (stall_cnt < 5) begin
          ring_if.out_ready = 1'b0;
          stall_cnt++;
        end else begin
          ring_if.out_ready = 1'b1;
          stall_cnt = 0;
        end
      end else begin
        ring_if.out_ready = 1'b0;
        stall_cnt = 0;
      end
    end
  end

  // Monitor: samples on the falling edge, away from the active edge.
  always @(negedge clk) begin
    if (rst) begin
      busy_cycles = 0;
      prev_hold   = 0;
      prev_done   = 0;
    end else begin
      if (prev_hold) begin
        check("stall_valid_held", ring_if.out_valid, 1);
        check("stall_x_stable", ring_if.out_x, hold_x);
        check("stall_y_stable", ring_if.out_y, hold_y);
      end
      if (prev_done) begin
        check("busy_after_done", ring_if.busy, 0);
        check("done_one_cycle", ring_if.done, 0);
      end
      prev_done = 0;
      if (ring_if.busy) busy_cycles++;
      if (ring_if.out_valid && ring_if.out_ready) begin
        check("point_expected", exp_q.size() > 0, 1);
        if (exp_q.size() > 0) begin
          pt_t p;
          int dx, dy, idx;
          p = exp_q.pop_front();
          check("point_x", ring_if.out_x, p.x);
          check("point_y", ring_if.out_y, p.y);
          dx = int'(ring_if.out_x) - cur_cx;
          dy = int'(ring_if.out_y) - cur_cy;
          check("point_distance", (dx < 0 ? -dx : dx) + (dy < 0 ? -dy : dy), cur_r);
          idx = int'(ring_if.out_x) * 16 + int'(ring_if.out_y);
          check("point_no_dup", seen[idx], 0);
          seen[idx] = 1;
        end
        pts_seen++;
        prev_hold = 0;
      end else if (ring_if.out_valid) begin
        prev_hold = 1;
        hold_x = ring_if.out_x;
        hold_y = ring_if.out_y;
      end else begin
        prev_hold = 0;
      end
      if (ring_if.done) begin
        check("done_run_expected", run_q.size() > 0, 1);
        check("done_with_busy", ring_if.busy, 1);
        if (run_q.size() > 0) begin
          run_t e;
          e = run_q.pop_front();
          check("point_count", ring_if.point_count, e.cnt);
          check("busy_cycles", busy_cycles, e.cyc);
        end
        busy_cycles = 0;
        prev_done = 1;
        done_seen++;
      end
    end
  end

  task automatic start_run(input int cx, input int cy, input int r,
                           input int cnt, input int cyc, output int d0);
    int t;
    run_t e;
    e.cnt = cnt;
    e.cyc = cyc;
    if (cnt >= 0) run_q.push_back(e);
    cur_cx = cx;
    cur_cy = cy;
    cur_r  = r;
    for (int i = 0; i < 256; i++) seen[i] = 0;
    for (t = 0; t < 200 && ring_if.busy; t++) begin
      @(posedge clk);
      #1;
    end
    check("idle_before_start", ring_if.busy, 0);
    d0 = done_seen;
    ring_if.center_x = 4'(cx);
    ring_if.center_y = 4'(cy);
    ring_if.radius   = 4'(r);
    ring_if.start    = 1'b1;
    @(posedge clk);
    #1;
    ring_if.start    = 1'b0;
  endtask

  task automatic wait_done(input int d0);
    for (int t = 0; t < 400 && done_seen == d0; t++) begin
      @(posedge clk);
      #1;
    end
    check("done_within_budget", done_seen > d0, 1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, required finish before 200000");
    $fatal(1, "watchdog");
  end

  initial begin
    int d0, p0;
    rst = 1'b1;
    ring_if.start = 1'b0;
    ring_if.center_x = '0;
    ring_if.center_y = '0;
    ring_if.radius = '0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_out_valid", ring_if.out_valid, 0);
    check("rst_out_x", ring_if.out_x, 0);
    check("rst_out_y", ring_if.out_y, 0);
    check("rst_busy", ring_if.busy, 0);
    check("rst_done", ring_if.done, 0);
    check("rst_point_count", ring_if.point_count, 0);
    rst = 1'b0;
    @(posedge clk);
    #1;

    // R=0 at (5,5)
    push_pt(5, 5);
    start_run(5, 5, 0, 1, 3, d0);
    wait_done(d0);

    // R=1 at (8,8), with start-latency probes
    push_pt(9, 8); push_pt(8, 9); push_pt(7, 8); push_pt(8, 7);
    start_run(8, 8, 1, 4, 9, d0);
    check("lat_busy_cycle1", ring_if.busy, 1);
    check("lat_valid_cycle1", ring_if.out_valid, 0);
    @(posedge clk);
    #1;
    check("lat_valid_cycle2", ring_if.out_valid, 1);
    wait_done(d0);

    // R=2 at corner (0,0): five off-grid candidates skipped
    push_pt(2, 0); push_pt(1, 1); push_pt(0, 2);
    start_run(0, 0, 2, 3, 12, d0);
    wait_done(d0);

    // R=15 at (15,15): only segment 2 and the first of segment 3 land on grid
    for (int i = 0; i < 15; i++) push_pt(i, 15 - i);
    push_pt(15, 0);
    start_run(15, 15, 15, 16, 77, d0);
    wait_done(d0);

    // Backpressure plus an ignored start mid-run: 4 scans + 4*6 emits + done
    stall_en = 1;
    push_pt(9, 8); push_pt(8, 9); push_pt(7, 8); push_pt(8, 7);
    start_run(8, 8, 1, 4, 29, d0);
    repeat (3) @(posedge clk);
    #1;
    ring_if.center_x = 4'd0;
    ring_if.center_y = 4'd0;
    ring_if.radius   = 4'd3;
    ring_if.start    = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    ring_if.start    = 1'b0;
    wait_done(d0);

    // Reset during the EMIT of the 2nd point
    push_pt(9, 8); push_pt(8, 9); push_pt(7, 8); push_pt(8, 7);
    p0 = pts_seen;
    start_run(8, 8, 1, -1, 0, d0);
    for (int t = 0; t < 200 && !(pts_seen == p0 + 1 && ring_if.out_valid); t++) begin
      @(posedge clk);
      #1;
    end
    check("second_point_presented", ring_if.out_valid, 1);
    #2;
    rst = 1'b1;
    #1;
    check("midrun_rst_out_valid", ring_if.out_valid, 0);
    check("midrun_rst_out_x", ring_if.out_x, 0);
    check("midrun_rst_out_y", ring_if.out_y, 0);
    check("midrun_rst_busy", ring_if.busy, 0);
    check("midrun_rst_done", ring_if.done, 0);
    check("midrun_rst_point_count", ring_if.point_count, 0);
    exp_q.delete();
    stall_en = 0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    @(posedge clk);
    #1;

    // Fresh run after reset
    push_pt(4, 3); push_pt(3, 4); push_pt(2, 3); push_pt(3, 2);
    start_run(3, 3, 1, 4, 9, d0);
    wait_done(d0);
    repeat (2) @(posedge clk);
    #1;
    check("points_left_over", exp_q.size(), 0);
    check("runs_left_over", run_q.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
